// File: rtl/config_chain_receiver.sv
// Serial configuration chain receiver: oversamples async prog_* lines, shifts an N-bit chain
// (bit 0 first, tail on prog_out) and commits a correct-length frame to cfg_out on prog_en fall.
module config_chain_receiver #(
  parameter int N           = 1480,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         prog_in,
  input  logic         prog_clk,
  input  logic         prog_en,
  output logic         prog_out,
  output logic [N-1:0] cfg_out,
  output logic         cfg_valid,
  output logic         load_err,
  output logic         busy
);

  localparam int CW = $clog2(N + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] pclk_sync_q, pin_sync_q, pen_sync_q;
  logic                   pclk_d1_q, pen_d1_q;
  logic                   pclk_s, pin_s, pen_s;
  logic                   pclk_rise, pen_rise, pen_fall;

  state_t         state_q;
  logic [N-1:0]   shift_q, shift_d, cfg_q;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           cfg_valid_q, load_err_q, busy_q, pen_pend_q;

  // All three lines share one depth so data stays aligned with its strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pclk_sync_q <= '0;
      pin_sync_q  <= '0;
      pen_sync_q  <= '0;
      pclk_d1_q   <= 1'b0;
      pen_d1_q    <= 1'b0;
    end else begin
      pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], prog_clk};
      pin_sync_q  <= {pin_sync_q[SYNC_STAGES-2:0], prog_in};
      pen_sync_q  <= {pen_sync_q[SYNC_STAGES-2:0], prog_en};
      pclk_d1_q   <= pclk_s;
      pen_d1_q    <= pen_s;
    end
  end

  assign pclk_s    = pclk_sync_q[SYNC_STAGES-1];
  assign pin_s     = pin_sync_q[SYNC_STAGES-1];
  assign pen_s     = pen_sync_q[SYNC_STAGES-1];
  assign pclk_rise = pclk_s & ~pclk_d1_q;
  assign pen_rise  = pen_s & ~pen_d1_q;
  assign pen_fall  = ~pen_s & pen_d1_q;

  assign shift_d   = {pin_s, shift_q[N-1:1]};
  // Saturate at N+1 so an over-length frame can never alias to N.
  assign bit_cnt_d = (bit_cnt_q == CW'(N + 1)) ? bit_cnt_q : bit_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cfg_q       <= '0;
      bit_cnt_q   <= '0;
      cfg_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      pen_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pen_rise || pen_pend_q) begin
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            pen_pend_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (pen_fall) begin
            state_q <= COMMIT;
            busy_q  <= 1'b0;
          end else if (pclk_rise && pen_s) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (bit_cnt_q == CW'(N)) begin
            cfg_q       <= shift_q;
            cfg_valid_q <= 1'b1;
            load_err_q  <= 1'b0;
          end else begin
            load_err_q  <= 1'b1;
          end
          // A new frame may start while we commit; remember it for IDLE.
          if (pen_rise) pen_pend_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign prog_out  = shift_q[0];
  assign cfg_out   = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign load_err  = load_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_config_chain_receiver.sv
// Bench for config_chain_receiver: N=8 instance (table, hand sequences, random frames vs a
// queue model of the chain) and an N=1480 instance (two-frame readback regression).
module tb_config_chain_receiver;

  localparam int NS = 8;
  localparam int NB = 1480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, prog_in, prog_clk, en, use_big;
  logic pen_s_in, pen_b_in;
  logic prog_out_s, cfg_valid_s, load_err_s, busy_s;
  logic prog_out_b, cfg_valid_b, load_err_b, busy_b;
  logic [NS-1:0] cfg_out_s;
  logic [NB-1:0] cfg_out_b;
  logic cur_out;

  assign pen_s_in = en & ~use_big;
  assign pen_b_in = en & use_big;
  assign cur_out  = use_big ? prog_out_b : prog_out_s;

  config_chain_receiver #(.N(NS), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .prog_in(prog_in), .prog_clk(prog_clk), .prog_en(pen_s_in),
    .prog_out(prog_out_s), .cfg_out(cfg_out_s), .cfg_valid(cfg_valid_s),
    .load_err(load_err_s), .busy(busy_s));

  config_chain_receiver #(.N(NB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .prog_in(prog_in), .prog_clk(prog_clk), .prog_en(pen_b_in),
    .prog_out(prog_out_b), .cfg_out(cfg_out_b), .cfg_valid(cfg_valid_b),
    .load_err(load_err_b), .busy(busy_b));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: the chain as a FIFO of bits, front = tail (prog_out).
  bit         mq[$];
  logic [NS-1:0] cfg_e;
  logic       vld_e, err_e;

  typedef struct {
    logic [15:0]   data;
    int            nbits;
    logic [NS-1:0] exp_cfg;
    logic          exp_vld;
    logic          exp_err;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NS; i++) mq.push_back(1'b0);
    cfg_e = '0; vld_e = 1'b0; err_e = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit do_chk, input bit exp_out);
    prog_in = b;
    cyc(1);
    if (do_chk) chk("prog_out_before_shift", cur_out, exp_out);
    prog_clk = 1'b1;
    cyc(4);
    prog_clk = 1'b0;
    cyc(4);
  endtask

  task automatic shift_bits(input logic [15:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      send_bit(data[i], 1'b1, mq[0]);
      mq.push_back(data[i]);
      void'(mq.pop_front());
    end
  endtask

  task automatic model_commit(input int nbits);
    if (nbits == NS) begin
      for (int k = 0; k < NS; k++) cfg_e[k] = mq[k];
      vld_e = 1'b1; err_e = 1'b0;
    end else begin
      err_e = 1'b1;
    end
  endtask

  task automatic small_frame(input logic [15:0] data, input int nbits);
    en = 1'b1;
    cyc(4);
    chk("busy_in_frame", busy_s, 1'b1);
    shift_bits(data, nbits);
    en = 1'b0;
    cyc(4);
    chk("busy_after_fall", busy_s, 1'b0);
    cyc(2);
    model_commit(nbits);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_cfg"}, cfg_out_s, cfg_e);
    chk({tag, "_vld"}, cfg_valid_s, vld_e);
    chk({tag, "_err"}, load_err_s, err_e);
    chk({tag, "_pout"}, prog_out_s, mq[0]);
  endtask

  logic [NB-1:0] fa, fb;
  logic [7:0] saved_out;
  int first_bad;

  initial begin
    tbl[0] = '{16'h00A6, 8, 8'hA6, 1'b1, 1'b0};
    tbl[1] = '{16'h003C, 8, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{16'h007F, 7, 8'h3C, 1'b1, 1'b1};
    tbl[3] = '{16'h01FF, 9, 8'h3C, 1'b1, 1'b1};
    tbl[4] = '{16'h0000, 0, 8'h3C, 1'b1, 1'b1};
    tbl[5] = '{16'h0055, 8, 8'h55, 1'b1, 1'b0};

    reset_n = 1'b0; prog_in = 1'b0; prog_clk = 1'b0; en = 1'b0; use_big = 1'b0;
    model_reset();
    cyc(3);
    chk("rst_pout", prog_out_s, 1'b0);
    chk("rst_cfg", cfg_out_s, '0);
    chk("rst_vld", cfg_valid_s, 1'b0);
    chk("rst_err", load_err_s, 1'b0);
    chk("rst_busy", busy_s, 1'b0);
    reset_n = 1'b1;
    cyc(3);

    for (int t = 0; t < 6; t++) begin
      small_frame(tbl[t].data, tbl[t].nbits);
      chk($sformatf("tbl%0d_cfg", t), cfg_out_s, tbl[t].exp_cfg);
      chk($sformatf("tbl%0d_vld", t), cfg_valid_s, tbl[t].exp_vld);
      chk($sformatf("tbl%0d_err", t), load_err_s, tbl[t].exp_err);
    end

    // Strobes with prog_en low must not touch the chain or commit anything.
    saved_out = cfg_out_s;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom), 1'b0, 1'b0);
      chk("idle_pout", prog_out_s, mq[0]);
      chk("idle_busy", busy_s, 1'b0);
    end
    cyc(4);
    chk("idle_cfg", cfg_out_s, saved_out);
    chk_model("idle");

    // prog_en low for one cycle: the new frame's rise lands during COMMIT.
    en = 1'b1;
    cyc(4);
    shift_bits(16'h00C3, 8);
    model_commit(8);
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    cyc(6);
    chk("b2b_busy", busy_s, 1'b1);
    shift_bits(16'h0081, 8);
    en = 1'b0;
    cyc(6);
    model_commit(8);
    chk("b2b_cfg", cfg_out_s, 8'h81);
    chk_model("b2b");

    // Reset in the middle of a frame.
    en = 1'b1;
    cyc(4);
    shift_bits(16'h00F0, 4);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_cfg", cfg_out_s, '0);
    chk("midrst_vld", cfg_valid_s, 1'b0);
    chk("midrst_pout", prog_out_s, 1'b0);
    chk("midrst_busy", busy_s, 1'b0);
    chk("midrst_err", load_err_s, 1'b0);
    en = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    small_frame(16'h00FF, 8);
    chk("after_rst_cfg", cfg_out_s, 8'hFF);
    chk_model("after_rst");

    for (int r = 0; r < 10; r++) begin
      int nb;
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : NS;
      small_frame(16'($urandom), nb);
      chk_model($sformatf("rnd%0d", r));
    end

    // Full-length regression on the default-size instance.
    use_big = 1'b1;
    for (int i = 0; i < NB; i++) begin
      fa[i] = 1'($urandom);
      fb[i] = 1'($urandom);
    end
    en = 1'b1;
    cyc(4);
    for (int i = 0; i < NB; i++) send_bit(fa[i], 1'b1, 1'b0);
    en = 1'b0;
    cyc(6);
    chk("big_a_vld", cfg_valid_b, 1'b1);
    chk("big_a_err", load_err_b, 1'b0);
    en = 1'b1;
    cyc(4);
    for (int i = 0; i < NB; i++) send_bit(fb[i], 1'b1, fa[i]);
    en = 1'b0;
    cyc(6);
    n_chk++;
    if (cfg_out_b !== fb) begin
      n_fail++;
      first_bad = -1;
      for (int i = NB - 1; i >= 0; i--) if (cfg_out_b[i] !== fb[i]) first_bad = i;
      $display("FAIL big_b_cfg: cfg_out differs from frame B, lowest bad bit %0d got %b expected %b",
               first_bad, cfg_out_b[first_bad], fb[first_bad]);
    end
    chk("big_b_err", load_err_b, 1'b0);
    chk("big_b_busy", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/config_chain_receiver.md
Name: config_chain_receiver

Overview:
- Receiving end of the serial fabric-configuration protocol (prog_in / prog_clk / prog_en / prog_out) used to load fpgav2 settings.
- Oversamples the programmer's asynchronous prog_* lines on the fabric clock and shifts bits into an N-bit chain, bit 0 first.
- Presents the previous chain contents on prog_out for readback or verify, so instances daisy-chain.
- Commits a complete frame to a parallel active-config register when prog_en falls.

Parameters:
N, 1480, configuration frame length in bits
SYNC_STAGES, 2, synchroniser depth on prog_clk/prog_in/prog_en (min 2)

Ports:
clk  input  1  fabric clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
prog_in  input  1  serial config data from programmer (async)
prog_clk  input  1  programmer shift strobe (async, treated as data)
prog_en  input  1  frame enable, high for whole frame (async)
prog_out  output  1  chain tail = shift_reg[0]; readback / next segment's prog_in
cfg_out  output  N  committed active configuration
cfg_valid  output  1  high once a correct-length frame has committed
load_err  output  1  last frame had wrong bit count (sticky until next good commit)
busy  output  1  high while in SHIFT state

Behaviour:
- Reset (async assert, sync release): shift_reg=0, cfg_out=0, cfg_valid=0, load_err=0, busy=0, bit_cnt=0, FSM=IDLE, all sync flops 0.
- prog_out=0 after reset.
- Synchronisers: prog_clk, prog_in and prog_en each pass through SYNC_STAGES flops (identical depth, kept aligned).
  - Outputs are pclk_s, pin_s, pen_s; one extra flop on pclk_s and pen_s gives edge detection.
- Shift event: rising edge of pclk_s while pen_s==1.
  - shift_reg <= {pin_s, shift_reg[N-1:1]}.
  - bit_cnt <= bit_cnt+1, saturating at N+1.
  - Latency, prog_clk pin rise to prog_out update: SYNC_STAGES+1 clk cycles (3 at default).
- Programmer timing contract: prog_clk high and low each >= SYNC_STAGES+1 clk periods; prog_in stable from >= 1 clk period before prog_clk rises until it falls.
- Shift order: after exactly N shifts, shift_reg[k] = k-th bit sent (index 0 first).
  - During a frame, before shift i, prog_out shows the old frame's bit i.
- FSM states:
  - IDLE: busy=0. pen_s rise -> SHIFT, bit_cnt<=0.
  - SHIFT: busy=1. Shift events processed. pen_s fall -> COMMIT.
  - COMMIT: one cycle, then IDLE.
    - If bit_cnt==N: cfg_out<=shift_reg, cfg_valid<=1, load_err<=0.
    - Otherwise: load_err<=1; cfg_out and cfg_valid unchanged.
- Boundary conditions:
  - pclk_s rise in the same cycle pen_s falls: pen_s==0, so the edge is ignored (not shifted).
  - Shift events in IDLE/COMMIT: ignored; shift_reg and prog_out unchanged.
  - Over-length frame: bit_cnt saturates at N+1, so it can never wrap back to N; commit fails with load_err.
  - Zero-length frame (prog_en pulse with no clocks): load_err=1.
  - pen_s rising during COMMIT: taken in IDLE next cycle. Edge register holds it; not lost.
  - reset_n asserted mid-frame: everything returns to reset values immediately and the frame is discarded. cfg_valid=0 until a full new frame commits.
  - shift_reg is not restored on a failed commit; readback then reflects the partial shift.

Test Plan:
- Bench uses N=8, clk 10 ns, prog_clk phases 40 ns.
- Reset, then send 8'b1010_0110 bit 0 first -> cfg_out=8'hA6, cfg_valid=1, load_err=0, busy low within 4 cycles of prog_en fall.
- Second frame 8'h3C after 8'hA6 -> before each shift i, prog_out==bit i of 8'hA6; final cfg_out=8'h3C.
- Frame with 7 clocks, then one with 9 clocks, after a good 8'h3C -> load_err=1 each time; cfg_out stays 8'h3C; cfg_valid stays 1.
- prog_clk pulses with prog_en=0 -> shift_reg/prog_out unchanged, busy=0, no commit.
- reset_n low after 4 of 8 bits -> immediately cfg_out=0, cfg_valid=0, prog_out=0, busy=0. A following full frame 8'hFF commits normally.
- N=1480 regression: random frame A, then frame B -> readback during B matches A bit-for-bit; cfg_out==B.
